// File: rtl/usb_rx_pkg.sv
// Shared constants for the USB receive bit decoder: FSM state codes, bit-stuffing
// run length, SYNC length and J/K line levels.
package usb_rx_pkg;

    typedef logic [1:0] usb_rx_state_t;

    localparam usb_rx_state_t StIdle  = 2'd0;
    localparam usb_rx_state_t StData  = 2'd1;
    localparam usb_rx_state_t StEop   = 2'd2;
    localparam usb_rx_state_t StError = 2'd3;

    localparam int unsigned USB_STUFF_RUN = 6;
    localparam int unsigned USB_SYNC_LEN  = 8;

    localparam logic LINE_J = 1'b1;
    localparam logic LINE_K = 1'b0;

endpackage

// File: rtl/usb_bit_unstuffer.sv
// Bit unstuffer: tracks consecutive decoded ones, drops the stuffed zero that follows
// a full run and flags a one in that position as a stuff error.
module usb_bit_unstuffer (
    input  logic clk48,
    input  logic RST,
    input  logic strobe,
    input  logic din,
    input  logic clear,
    output logic bit_valid,
    output logic dout,
    output logic stuff_error
);
    import usb_rx_pkg::*;

    logic [2:0] ones_cnt_q, ones_cnt_d;
    logic       at_limit;

    always_comb begin
        at_limit    = (ones_cnt_q == 3'(USB_STUFF_RUN));
        bit_valid   = strobe & ~at_limit;
        stuff_error = strobe & at_limit & din;
        dout        = din;
        ones_cnt_d  = ones_cnt_q;
        if (clear) begin
            ones_cnt_d = 3'd0;
        end else if (strobe) begin
            if (at_limit || !din) begin
                ones_cnt_d = 3'd0;
            end else begin
                ones_cnt_d = ones_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk48 or posedge RST) begin
        if (RST) begin
            ones_cnt_q <= 3'd0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
        end
    end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: NRZI decode, SYNC hunt, unstuffing, LSB-first byte assembly
// and EOP detection. Define USB_RX_STRICT_SYNC_EN to require exactly 7 SYNC zeros.
module usb_rx_bit_decoder #(
    parameter int unsigned SYNC_MIN_ZEROS = 5
) (
    input  logic       clk48,
    input  logic       RST,
    input  logic       readCLK12,
    input  logic       data,
    input  logic       se0,
    output logic       rxActive,
    output logic [7:0] rxByte,
    output logic       rxByteValid,
    output logic       rxEop,
    output logic       rxStuffError,
    output logic       rxAlignError
);
    import usb_rx_pkg::*;

    logic          readclk_q;
    logic          prev_data_q, prev_data_d;
    usb_rx_state_t state_q, state_d;
    logic [2:0]    zero_cnt_q, zero_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          from_err_q, from_err_d;
    logic          rx_active_q, rx_active_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          byte_valid_q, byte_valid_d;
    logic          eop_q, eop_d;
    logic          stuff_err_q, stuff_err_d;
    logic          align_err_q, align_err_d;

    logic strobe, nrzi_bit, sync_ok;
    logic us_strobe, us_clear, us_valid, us_bit, us_err;

    assign strobe    = readCLK12 & ~readclk_q;
    assign nrzi_bit  = (data == prev_data_q);
    assign us_strobe = strobe & ~se0 & (state_q == StData);
    assign us_clear  = (state_q != StData);

`ifdef USB_RX_STRICT_SYNC_EN
    assign sync_ok = (zero_cnt_q == 3'(USB_SYNC_LEN - 1));
`else
    assign sync_ok = (32'(zero_cnt_q) >= SYNC_MIN_ZEROS);
`endif

    usb_bit_unstuffer u_unstuffer (
        .clk48       (clk48),
        .RST         (RST),
        .strobe      (us_strobe),
        .din         (nrzi_bit),
        .clear       (us_clear),
        .bit_valid   (us_valid),
        .dout        (us_bit),
        .stuff_error (us_err)
    );

    always_comb begin
        prev_data_d  = prev_data_q;
        state_d      = state_q;
        zero_cnt_d   = zero_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        from_err_d   = from_err_q;
        rx_active_d  = rx_active_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        eop_d        = 1'b0;
        stuff_err_d  = 1'b0;
        align_err_d  = 1'b0;

        if (strobe && !se0) begin
            prev_data_d = data;
        end

        if (strobe) begin
            case (state_q)
                StIdle: begin
                    if (!se0) begin
                        if (!nrzi_bit) begin
`ifdef USB_RX_STRICT_SYNC_EN
                            // An eighth zero cannot be SYNC: restart the hunt
                            zero_cnt_d = (zero_cnt_q == 3'd7) ? 3'd0 : zero_cnt_q + 3'd1;
`else
                            zero_cnt_d = (zero_cnt_q == 3'd7) ? 3'd7 : zero_cnt_q + 3'd1;
`endif
                        end else if (sync_ok) begin
                            state_d     = StData;
                            rx_active_d = 1'b1;
                            zero_cnt_d  = 3'd0;
                            bit_cnt_d   = 3'd0;
                            from_err_d  = 1'b0;
                        end else begin
                            zero_cnt_d = 3'd0;
                        end
                    end
                end
                StData: begin
                    if (se0) begin
                        state_d = StEop;
                    end else if (us_err) begin
                        stuff_err_d = 1'b1;
                        state_d     = StError;
                    end else if (us_valid) begin
                        shift_d = {us_bit, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            rx_byte_d    = shift_d;
                            byte_valid_d = 1'b1;
                            bit_cnt_d    = 3'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                StEop: begin
                    if (!se0) begin
                        eop_d       = 1'b1;
                        align_err_d = ~from_err_q & ((data == LINE_K) | (bit_cnt_q != 3'd0));
                        rx_active_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: begin
                    if (se0) begin
                        from_err_d = 1'b1;
                        state_d    = StEop;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk48 or posedge RST) begin
        if (RST) begin
            readclk_q    <= 1'b0;
            prev_data_q  <= LINE_J;
            state_q      <= StIdle;
            zero_cnt_q   <= 3'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            from_err_q   <= 1'b0;
            rx_active_q  <= 1'b0;
            rx_byte_q    <= 8'h00;
            byte_valid_q <= 1'b0;
            eop_q        <= 1'b0;
            stuff_err_q  <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            readclk_q    <= readCLK12;
            prev_data_q  <= prev_data_d;
            state_q      <= state_d;
            zero_cnt_q   <= zero_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            from_err_q   <= from_err_d;
            rx_active_q  <= rx_active_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            eop_q        <= eop_d;
            stuff_err_q  <= stuff_err_d;
            align_err_q  <= align_err_d;
        end
    end

    assign rxActive     = rx_active_q;
    assign rxByte       = rx_byte_q;
    assign rxByteValid  = byte_valid_q;
    assign rxEop        = eop_q;
    assign rxStuffError = stuff_err_q;
    assign rxAlignError = align_err_q;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Bench for usb_rx_bit_decoder: builds packets from bytes (SYNC, stuffing, NRZI, EOP)
// and compares received bytes and strobes against what was sent.
module tb_usb_rx_bit_decoder;

    logic       clk48 = 1'b0;
    logic       RST;
    logic       readCLK12;
    logic       data;
    logic       se0;
    logic       rxActive;
    logic [7:0] rxByte;
    logic       rxByteValid;
    logic       rxEop;
    logic       rxStuffError;
    logic       rxAlignError;

    int tests_run    = 0;
    int tests_failed = 0;

    // Recorded DUT activity
    logic [7:0] got_bytes[$];
    int         eop_cnt, align_cnt, stuff_cnt, eop_active_cnt, stray_align_cnt;
    logic       active_seen;

    // Line encoder state
    logic tb_level;
    int   tb_ones;

    usb_rx_bit_decoder dut (
        .clk48        (clk48),
        .RST          (RST),
        .readCLK12    (readCLK12),
        .data         (data),
        .se0          (se0),
        .rxActive     (rxActive),
        .rxByte       (rxByte),
        .rxByteValid  (rxByteValid),
        .rxEop        (rxEop),
        .rxStuffError (rxStuffError),
        .rxAlignError (rxAlignError)
    );

    always #10 clk48 = ~clk48;

    always @(negedge clk48) begin
        if (!RST) begin
            if (rxByteValid) got_bytes.push_back(rxByte);
            if (rxEop) eop_cnt++;
            if (rxAlignError) align_cnt++;
            if (rxStuffError) stuff_cnt++;
            if (rxEop && rxActive) eop_active_cnt++;
            if (rxAlignError && !rxEop) stray_align_cnt++;
            if (rxActive) active_seen = 1'b1;
        end
    end

    task automatic clear_mon();
        @(posedge clk48);
        got_bytes.delete();
        eop_cnt = 0; align_cnt = 0; stuff_cnt = 0;
        eop_active_cnt = 0; stray_align_cnt = 0;
        active_seen = 1'b0;
    endtask

    task automatic drive_level(input logic lvl, input logic s0);
        @(negedge clk48);
        data = lvl; se0 = s0; readCLK12 = 1'b1;
        @(negedge clk48);
        @(negedge clk48);
        readCLK12 = 1'b0;
        @(negedge clk48);
    endtask

    // One decoded bit, NRZI encoded: 0 toggles the line, 1 holds it
    task automatic send_dec(input logic b);
        if (!b) tb_level = ~tb_level;
        drive_level(tb_level, 1'b0);
    endtask

    task automatic send_data_bit(input logic b);
        send_dec(b);
        tb_ones = b ? tb_ones + 1 : 0;
        if (tb_ones == 6) begin
            send_dec(1'b0);
            tb_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_dec(1'b1);
    endtask

    task automatic send_sync(input int zeros);
        for (int i = 0; i < zeros; i++) send_dec(1'b0);
        send_dec(1'b1);
        tb_ones = 0;
    endtask

    task automatic send_eop();
        drive_level(1'b0, 1'b1);
        drive_level(1'b0, 1'b1);
        tb_level = 1'b1;
        drive_level(1'b1, 1'b0);
        send_idle(3);
    endtask

    task automatic check_packet(input string name, input logic [7:0] exp_bytes[$],
                                input int exp_align);
        tests_run++;
        if (got_bytes.size() !== exp_bytes.size()) begin
            tests_failed++;
            $display("FAIL %s byte_count got=%0d exp=%0d", name, got_bytes.size(),
                     exp_bytes.size());
        end
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
            tests_run++;
            if (got_bytes[i] !== exp_bytes[i]) begin
                tests_failed++;
                $display("FAIL %s byte[%0d] got=%h exp=%h", name, i, got_bytes[i], exp_bytes[i]);
            end
        end
        tests_run++;
        if (eop_cnt !== 1) begin
            tests_failed++;
            $display("FAIL %s eop_count got=%0d exp=1", name, eop_cnt);
        end
        tests_run++;
        if (align_cnt !== exp_align) begin
            tests_failed++;
            $display("FAIL %s align_count got=%0d exp=%0d", name, align_cnt, exp_align);
        end
        tests_run++;
        if (stuff_cnt !== 0 || eop_active_cnt !== 0 || stray_align_cnt !== 0) begin
            tests_failed++;
            $display("FAIL %s side_flags stuff=%0d eop_active=%0d stray_align=%0d exp=0/0/0",
                     name, stuff_cnt, eop_active_cnt, stray_align_cnt);
        end
        tests_run++;
        if (active_seen !== 1'b1 || rxActive !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s active seen=%b now=%b exp=1/0", name, active_seen, rxActive);
        end
    endtask

    task automatic test_reset();
        @(negedge clk48);
        tests_run++;
        if ({rxActive, rxByteValid, rxEop, rxStuffError, rxAlignError} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {rxActive, rxByteValid, rxEop, rxStuffError, rxAlignError});
        end
        tests_run++;
        if (rxByte !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_byte got=%h exp=00", rxByte);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp[$];
        clear_mon();
        send_idle(4);
        send_sync(7);
        send_byte(8'hA5);
        send_eop();
        exp = '{8'hA5};
        check_packet("basic_a5", exp, 0);
    endtask

    task automatic test_stuffing();
        logic [7:0] exp[$];
        clear_mon();
        send_idle(2);
        send_sync(7);
        send_byte(8'hFF);
        send_byte(8'h7E);
        send_eop();
        exp = '{8'hFF, 8'h7E};
        check_packet("stuff_ff_7e", exp, 0);
    endtask

    task automatic test_random();
        logic [7:0] exp[$];
        logic [7:0] v;
        int         nb, extra;
        for (int p = 0; p < 12; p++) begin
            clear_mon();
            exp.delete();
            nb    = $urandom_range(1, 4);
            extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            send_idle($urandom_range(1, 4));
            send_sync(7);
            for (int i = 0; i < nb; i++) begin
                v = 8'($urandom);
                if ($urandom_range(0, 3) == 0) v = 8'hFF;
                exp.push_back(v);
                send_byte(v);
            end
            for (int i = 0; i < extra; i++) send_data_bit(1'($urandom));
            send_eop();
            check_packet($sformatf("random_%0d", p), exp, (extra != 0) ? 1 : 0);
        end
    endtask

    task automatic test_align();
        logic [7:0] exp[$];
        clear_mon();
        send_idle(2);
        send_sync(7);
        send_byte(8'h3C);
        send_data_bit(1'b1);
        send_data_bit(1'b0);
        send_data_bit(1'b1);
        send_eop();
        exp = '{8'h3C};
        check_packet("align_11bits", exp, 1);
    endtask

    task automatic test_stuff_error();
        clear_mon();
        send_idle(2);
        send_sync(7);
        for (int i = 0; i < 7; i++) send_dec(1'b1);
        for (int i = 0; i < 10; i++) send_dec(1'($urandom));
        tests_run++;
        if (rxActive !== 1'b1) begin
            tests_failed++;
            $display("FAIL stuff_err_active got=%b exp=1", rxActive);
        end
        send_eop();
        tests_run++;
        if (stuff_cnt !== 1) begin
            tests_failed++;
            $display("FAIL stuff_err_count got=%0d exp=1", stuff_cnt);
        end
        tests_run++;
        if (got_bytes.size() !== 0) begin
            tests_failed++;
            $display("FAIL stuff_err_bytes got=%0d exp=0", got_bytes.size());
        end
        tests_run++;
        if (eop_cnt !== 1 || align_cnt !== 0 || rxActive !== 1'b0) begin
            tests_failed++;
            $display("FAIL stuff_err_eop eop=%0d align=%0d active=%b exp=1/0/0",
                     eop_cnt, align_cnt, rxActive);
        end
    endtask

    task automatic test_short_sync();
        logic [7:0] exp[$];
        clear_mon();
        send_idle(3);
        send_sync(5);
        send_byte(8'h3C);
        send_eop();
`ifdef USB_RX_STRICT_SYNC_EN
        tests_run++;
        if (active_seen !== 1'b0 || got_bytes.size() !== 0 || eop_cnt !== 0) begin
            tests_failed++;
            $display("FAIL short_sync_strict active=%b bytes=%0d eop=%0d exp=0/0/0",
                     active_seen, got_bytes.size(), eop_cnt);
        end
`else
        exp = '{8'h3C};
        check_packet("short_sync", exp, 0);
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[$];
        clear_mon();
        send_idle(2);
        send_sync(7);
        for (int i = 0; i < 4; i++) send_data_bit(1'($urandom));
        tests_run++;
        if (rxActive !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_pre_active got=%b exp=1", rxActive);
        end
        #3;
        RST = 1'b1;
        #1;
        tests_run++;
        if ({rxActive, rxByteValid, rxEop, rxStuffError, rxAlignError, rxByte} !== 13'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_clear got=%b exp=0",
                     {rxActive, rxByteValid, rxEop, rxStuffError, rxAlignError, rxByte});
        end
        tb_level = 1'b1;
        readCLK12 = 1'b0;
        se0 = 1'b0;
        data = 1'b1;
        repeat (3) @(negedge clk48);
        RST = 1'b0;
        clear_mon();
        send_idle(3);
        send_sync(7);
        send_byte(8'h96);
        send_eop();
        exp = '{8'h96};
        check_packet("after_reset", exp, 0);
    endtask

    initial begin
        RST = 1'b1;
        readCLK12 = 1'b0;
        data = 1'b1;
        se0 = 1'b0;
        tb_level = 1'b1;
        tb_ones = 0;
        repeat (3) @(negedge clk48);
        RST = 1'b0;
        test_reset();
        test_basic();
        test_stuffing();
        test_align();
        test_stuff_error();
        test_short_sync();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
